// File: rtl/zdrode_link_pkg.sv
// Shared types and constants for the zdrode host-side byte-link transmitter.
// Bit positions mirror the chip's ui_in / uo_out pin assignment.
package zdrode_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MSB,
    ST_GAP,
    ST_LSB,
    ST_WAIT,
    ST_SEL,
    ST_DONE
  } state_t;

  localparam int unsigned BYTE_VALID_BIT         = 2;
  localparam int unsigned SEL_LSB                = 0;
  localparam int unsigned SPIKE_BIT              = 0;
  localparam int unsigned EVENT_LSB              = 1;
  localparam int unsigned DEFAULT_PROCESS_CYCLES = 2;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CH_W     = 2;
  localparam int unsigned EVENT_W  = 2;
  localparam int unsigned WAIT_W   = 4;

endpackage

// File: rtl/zdrode_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module zdrode_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/zdrode_host_link_tx.sv
// Host-side sample serialiser and result collector for the zdrode byte-link,
// with per-channel saturating spike counters.
module zdrode_host_link_tx
  import zdrode_link_pkg::*;
#(
  parameter int unsigned PROCESS_CYCLES = DEFAULT_PROCESS_CYCLES,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned NUM_UNITS      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CH_W-1:0]      s_channel,
  input  logic [SAMPLE_W-1:0]  s_sample,
  output logic [BYTE_W-1:0]    tx_data,
  output logic [BYTE_W-1:0]    tx_ctrl,
  input  logic [BYTE_W-1:0]    rx_status,
  output logic                 r_valid,
  output logic [CH_W-1:0]      r_channel,
  output logic                 r_spike,
  output logic [EVENT_W-1:0]   r_event,
  input  logic [CH_W-1:0]      cnt_sel,
  output logic [CNT_WIDTH-1:0] cnt_value,
  input  logic                 cnt_clear,
  output logic                 busy
);

  localparam logic [BYTE_W-1:0] CTRL_STROBE = BYTE_W'(1 << BYTE_VALID_BIT);
  localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_W'(PROCESS_CYCLES - 1);

  state_t                r_state,       w_state_nx;
  logic [SAMPLE_W-1:0]   r_sample,      w_sample_nx;
  logic [CH_W-1:0]       r_ch,          w_ch_nx;
  logic [BYTE_W-1:0]     r_tx_data,     w_tx_data_nx;
  logic [BYTE_W-1:0]     r_tx_ctrl,     w_tx_ctrl_nx;
  logic [WAIT_W-1:0]     r_wait,        w_wait_nx;
  logic                  r_res_valid,   w_res_valid_nx;
  logic [CH_W-1:0]       r_res_channel, w_res_channel_nx;
  logic                  r_res_spike,   w_res_spike_nx;
  logic [EVENT_W-1:0]    r_res_event,   w_res_event_nx;

  logic [BYTE_W-1:0]     w_sel_ctrl;
  logic [CNT_WIDTH-1:0]  w_cnt [NUM_UNITS];
  logic                  w_unused_status;

  assign w_sel_ctrl      = BYTE_W'(r_ch) << SEL_LSB;
  assign w_unused_status = ^rx_status[BYTE_W-1:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_sample      <= '0;
      r_ch          <= '0;
      r_tx_data     <= '0;
      r_tx_ctrl     <= '0;
      r_wait        <= '0;
      r_res_valid   <= 1'b0;
      r_res_channel <= '0;
      r_res_spike   <= 1'b0;
      r_res_event   <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_sample      <= w_sample_nx;
      r_ch          <= w_ch_nx;
      r_tx_data     <= w_tx_data_nx;
      r_tx_ctrl     <= w_tx_ctrl_nx;
      r_wait        <= w_wait_nx;
      r_res_valid   <= w_res_valid_nx;
      r_res_channel <= w_res_channel_nx;
      r_res_spike   <= w_res_spike_nx;
      r_res_event   <= w_res_event_nx;
    end
  end

  // Pin values are computed for the state being entered, so they change only on entry.
  always_comb begin
    w_state_nx       = r_state;
    w_sample_nx      = r_sample;
    w_ch_nx          = r_ch;
    w_tx_data_nx     = r_tx_data;
    w_tx_ctrl_nx     = '0;
    w_wait_nx        = r_wait;
    w_res_valid_nx   = 1'b0;
    w_res_channel_nx = r_res_channel;
    w_res_spike_nx   = r_res_spike;
    w_res_event_nx   = r_res_event;

    case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          w_state_nx   = ST_MSB;
          w_sample_nx  = s_sample;
          w_ch_nx      = s_channel;
          w_tx_data_nx = s_sample[SAMPLE_W-1:BYTE_W];
          w_tx_ctrl_nx = CTRL_STROBE;
        end
      end
      ST_MSB: begin
        w_state_nx = ST_GAP;
      end
      ST_GAP: begin
        w_state_nx   = ST_LSB;
        w_tx_data_nx = r_sample[BYTE_W-1:0];
        w_tx_ctrl_nx = CTRL_STROBE;
      end
      ST_LSB: begin
        w_state_nx = ST_WAIT;
        w_wait_nx  = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (r_wait == '0) begin
          w_state_nx   = ST_SEL;
          w_tx_ctrl_nx = w_sel_ctrl;
        end else begin
          w_wait_nx = r_wait - WAIT_W'(1);
        end
      end
      ST_SEL: begin
        w_state_nx       = ST_DONE;
        w_res_valid_nx   = 1'b1;
        w_res_channel_nx = r_ch;
        w_res_spike_nx   = rx_status[SPIKE_BIT];
        w_res_event_nx   = rx_status[EVENT_LSB +: EVENT_W];
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_cnt
    logic w_inc;
    assign w_inc = (r_state == ST_DONE) && r_res_spike && (r_res_channel == CH_W'(gi));
    zdrode_sat_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_inc),
      .clr   (cnt_clear),
      .count (w_cnt[gi])
    );
  end

  assign s_ready   = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign tx_data   = r_tx_data;
  assign tx_ctrl   = r_tx_ctrl;
  assign r_valid   = r_res_valid;
  assign r_channel = r_res_channel;
  assign r_spike   = r_res_spike;
  assign r_event   = r_res_event;
  assign cnt_value = w_cnt[cnt_sel];

endmodule

// File: tb/tb_zdrode_host_link_tx.sv
// Directed bench for zdrode_host_link_tx: a 16-bit-counter instance and a
// 4-bit-counter instance share all stimulus.
module tb_zdrode_host_link_tx;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [1:0]  s_channel;
  logic [15:0] s_sample;
  logic [7:0]  rx_status;
  logic [1:0]  cnt_sel;
  logic        cnt_clear;

  logic        s_ready, r_valid, r_spike, busy;
  logic [7:0]  tx_data, tx_ctrl;
  logic [1:0]  r_channel, r_event;
  logic [15:0] cnt16;

  logic        s_ready4, r_valid4, r_spike4, busy4;
  logic [7:0]  tx_data4, tx_ctrl4;
  logic [1:0]  r_channel4, r_event4;
  logic [3:0]  cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] e_ctrl  [7];
  logic [7:0] e_data  [7];
  logic       e_valid [7];

  zdrode_host_link_tx #(.PROCESS_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_channel(s_channel), .s_sample(s_sample), .tx_data(tx_data), .tx_ctrl(tx_ctrl),
    .rx_status(rx_status), .r_valid(r_valid), .r_channel(r_channel), .r_spike(r_spike),
    .r_event(r_event), .cnt_sel(cnt_sel), .cnt_value(cnt16), .cnt_clear(cnt_clear),
    .busy(busy)
  );

  zdrode_host_link_tx #(.PROCESS_CYCLES(2), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4),
    .s_channel(s_channel), .s_sample(s_sample), .tx_data(tx_data4), .tx_ctrl(tx_ctrl4),
    .rx_status(rx_status), .r_valid(r_valid4), .r_channel(r_channel4), .r_spike(r_spike4),
    .r_event(r_event4), .cnt_sel(cnt_sel), .cnt_value(cnt4), .cnt_clear(cnt_clear),
    .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one sample once ready; returns at the sampling point of cycle T0+1.
  task automatic send(input logic [1:0] ch, input logic [15:0] smp);
    int guard = 0;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (s_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL send_ready_timeout: s_ready=%b required 1", s_ready);
    end
    s_valid   = 1'b1;
    s_channel = ch;
    s_sample  = smp;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_result();
    int guard = 0;
    while (r_valid !== 1'b1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (r_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_timeout: r_valid=%b required 1", r_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({tx_data, tx_ctrl, r_valid, r_channel, r_spike, r_event, busy, s_ready} !== 17'h00001) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h ctrl=%h rv=%b ch=%0d sp=%b ev=%0d busy=%b rdy=%b required 00/00/0/0/0/0/0/1",
               tx_data, tx_ctrl, r_valid, r_channel, r_spike, r_event, busy, s_ready);
    end
    for (int c = 0; c < 4; c++) begin
      cnt_sel = 2'(c);
      #1;
      n_tests++;
      if (cnt16 !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_counter%0d: got %0d required 0", c, cnt16);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    e_ctrl  = '{8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h02, 8'h00};
    e_data  = '{8'h12, 8'h12, 8'h34, 8'h34, 8'h34, 8'h34, 8'h34};
    e_valid = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rx_status = 8'h00;
    cnt_sel   = 2'd2;
    send(2'd2, 16'h1234);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (tx_ctrl !== e_ctrl[i] || tx_data !== e_data[i] || r_valid !== e_valid[i] ||
          busy !== 1'b1 || s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_T0+%0d: ctrl=%h data=%h rv=%b busy=%b rdy=%b required %h/%h/%b/1/0",
                 i + 1, tx_ctrl, tx_data, r_valid, busy, s_ready, e_ctrl[i], e_data[i], e_valid[i]);
      end
    end
    n_tests++;
    if (r_channel !== 2'd2 || r_spike !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: ch=%0d sp=%b required 2/0", r_channel, r_spike);
    end
    @(negedge clk);
    n_tests++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1 || cnt16 !== 16'd0) begin
      n_fail++;
      $display("FAIL single_after: rv=%b rdy=%b cnt=%0d required 0/1/0", r_valid, s_ready, cnt16);
    end
  endtask

  task automatic test_spike();
    cnt_sel   = 2'd1;
    rx_status = 8'h05;
    send(2'd1, 16'h0F0F);
    wait_result();
    n_tests++;
    if (r_channel !== 2'd1 || r_spike !== 1'b1 || r_event !== 2'b10) begin
      n_fail++;
      $display("FAIL spike_result: ch=%0d sp=%b ev=%b required 1/1/10", r_channel, r_spike, r_event);
    end
    @(negedge clk);
    n_tests++;
    if (cnt16 !== 16'd1) begin
      n_fail++;
      $display("FAIL spike_count: got %0d required 1", cnt16);
    end
    rx_status = 8'h00;
    send(2'd1, 16'h0F0F);
    wait_result();
    n_tests++;
    if (r_spike !== 1'b0 || r_event !== 2'b00) begin
      n_fail++;
      $display("FAIL nospike_result: sp=%b ev=%b required 0/00", r_spike, r_event);
    end
    @(negedge clk);
    n_tests++;
    if (cnt16 !== 16'd1) begin
      n_fail++;
      $display("FAIL nospike_count: got %0d required 1", cnt16);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_c, exp_d;
    int n, ph;
    rx_status = 8'h00;
    s_valid   = 1'b1;
    s_channel = 2'd0;
    s_sample  = {8'h10, 8'h80};
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      n  = (k - 1) / 8;
      ph = k % 8;
      exp_c = 8'h00;
      exp_d = 8'h80 + 8'(n);
      if (ph == 1) exp_c = 8'h04;
      if (ph == 3) exp_c = 8'h04;
      if (ph == 6) exp_c = 8'(n);
      if (ph == 1 || ph == 2) exp_d = 8'h10 + 8'(n);
      n_tests++;
      if (tx_ctrl !== exp_c || tx_data !== exp_d || s_ready !== (ph == 0) || r_valid !== (ph == 7)) begin
        n_fail++;
        $display("FAIL b2b_k%0d: ctrl=%h data=%h rdy=%b rv=%b required %h/%h/%b/%b",
                 k, tx_ctrl, tx_data, s_ready, r_valid, exp_c, exp_d, ph == 0, ph == 7);
      end
      if (ph == 0) begin
        if (k == 32) begin
          s_valid = 1'b0;
        end else begin
          s_channel = 2'(n + 1);
          s_sample  = {8'h10 + 8'(n + 1), 8'h80 + 8'(n + 1)};
        end
      end
    end
  endtask

  task automatic test_saturation();
    cnt_sel   = 2'd3;
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    rx_status = 8'h01;
    for (int i = 1; i <= 20; i++) begin
      send(2'd3, 16'h5A5A);
      wait_result();
      @(negedge clk);
      if (i == 15 || i == 20) begin
        n_tests++;
        if (cnt4 !== 4'd15 || cnt16 !== 16'(i)) begin
          n_fail++;
          $display("FAIL sat_after_%0d: cnt4=%0d cnt16=%0d required 15/%0d", i, cnt4, cnt16, i);
        end
      end
      if (i == 14) begin
        n_tests++;
        if (cnt4 !== 4'd14) begin
          n_fail++;
          $display("FAIL sat_after_14: cnt4=%0d required 14", cnt4);
        end
      end
    end
  endtask

  task automatic test_clear_collision();
    cnt_sel   = 2'd0;
    rx_status = 8'h01;
    send(2'd0, 16'h0001);
    wait_result();
    @(negedge clk);
    n_tests++;
    if (cnt16 !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_pre: got %0d required 1", cnt16);
    end
    send(2'd0, 16'h0002);
    wait_result();
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    n_tests++;
    if (cnt16 !== 16'd0 || cnt4 !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_collision: cnt16=%0d cnt4=%0d required 0/0", cnt16, cnt4);
    end
  endtask

  task automatic test_reset_mid();
    cnt_sel   = 2'd1;
    rx_status = 8'h01;
    send(2'd1, 16'h5555);
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || tx_ctrl !== 8'h00 || tx_data !== 8'h55) begin
      n_fail++;
      $display("FAIL mid_pre: busy=%b ctrl=%h data=%h required 1/00/55", busy, tx_ctrl, tx_data);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx_ctrl !== 8'h00 || tx_data !== 8'h00 || r_valid !== 1'b0 || busy !== 1'b0 ||
        s_ready !== 1'b1 || cnt16 !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ctrl=%h data=%h rv=%b busy=%b rdy=%b cnt=%0d required 00/00/0/0/1/0",
               tx_ctrl, tx_data, r_valid, busy, s_ready, cnt16);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    rx_status = 8'h00;
    @(negedge clk);
    e_ctrl  = '{8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h02, 8'h00};
    e_data  = '{8'hAB, 8'hAB, 8'hCD, 8'hCD, 8'hCD, 8'hCD, 8'hCD};
    e_valid = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    send(2'd2, 16'hABCD);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (tx_ctrl !== e_ctrl[i] || tx_data !== e_data[i] || r_valid !== e_valid[i]) begin
        n_fail++;
        $display("FAIL post_reset_T0+%0d: ctrl=%h data=%h rv=%b required %h/%h/%b",
                 i + 1, tx_ctrl, tx_data, r_valid, e_ctrl[i], e_data[i], e_valid[i]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_channel = 2'd0;
    s_sample  = 16'h0000;
    rx_status = 8'h00;
    cnt_sel   = 2'd0;
    cnt_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_spike();
    test_back_to_back();
    test_saturation();
    test_clear_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
